truth_table_sweeper: RTL and testbench

- Self-running exhaustive stimulus generator and response checker for combinational lab blocks with N_IN inputs and N_OUT outputs.
- Drives every input vector in ascending binary order, waits a settle interval, then compares DUT outputs against a golden-model output under a mask.
- Counts mismatches and captures the first failing vector.
- Replaces hand-written per-row truth-table stimulus; instantiated next to the DUT and its golden model on the lab board or in a bench.

---
 rtl/truth_table_sweeper.sv | 153 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector in ascending order,
// holds each for SETTLE_CYC cycles, then compares dut_out vs exp_out under a latched mask.
// Optional build macro TTS_STOP_ON_FAIL_EN: the first failing compare ends the sweep.
module truth_table_sweeper #(
   parameter int N_IN       = 3,
   parameter int N_OUT      = 2,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [N_OUT-1:0] cmp_mask,
   input  logic [N_OUT-1:0] dut_out,
   input  logic [N_OUT-1:0] exp_out,
   output logic [N_IN-1:0]  stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    mismatch_cnt,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic             first_fail_valid
);

   // Settle counter only ever holds SETTLE_CYC-1 down to 0.
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
   localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);
   localparam logic [N_IN:0]   MM_ONE     = (N_IN + 1)'(1);

`ifdef TTS_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [N_IN-1:0]    stim_q, stim_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_OUT-1:0]   mask_q, mask_d;
   logic [N_IN:0]      mm_q, mm_d;
   logic [N_IN-1:0]    ffv_q, ffv_d;
   logic               ffvalid_q, ffvalid_d;
   logic               pass_q, pass_d;

   logic               fail;
   logic               last_vec;

   assign fail     = |((dut_out ^ exp_out) & mask_q);
   assign last_vec = &stim_q;

   // State register and result registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         stim_q    <= '0;
         cnt_q     <= '0;
         mask_q    <= '0;
         mm_q      <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         stim_q    <= stim_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         mm_q      <= mm_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         pass_q    <= pass_d;
      end
   end

   // Next-state logic: settle/check walk over vectors, abort drops back to IDLE.
   always_comb begin
      state_d   = state_q;
      stim_d    = stim_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      mm_d      = mm_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      pass_d    = pass_q;
      case (state_q)
         S_IDLE: begin
            // abort outranks start so a coincident pair never launches a sweep
            if (start && !abort) begin
               stim_d    = '0;
               mm_d      = '0;
               ffvalid_d = 1'b0;
               pass_d    = 1'b0;
               mask_d    = cmp_mask;
               cnt_d     = CNT_RELOAD;
               state_d   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_CHECK: begin
            // an abort landing on the compare cycle discards that compare
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (fail) begin
                  mm_d = mm_q + MM_ONE;
                  if (!ffvalid_q) begin
                     ffv_d     = stim_q;
                     ffvalid_d = 1'b1;
                  end
               end
               if (last_vec || (STOP_ON_FAIL && fail)) begin
                  state_d = S_DONE;
               end else begin
                  stim_d  = stim_q + STIM_ONE;
                  cnt_d   = CNT_RELOAD;
                  state_d = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            // mm_q already includes the final compare made in CHECK
            pass_d  = (mm_q == '0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stim             = stim_q;
   assign busy             = (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done             = (state_q == S_DONE);
   assign pass             = pass_q;
   assign mismatch_cnt     = mm_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (N_IN=3, N_OUT=2, SETTLE_CYC=2).
// Inputs driven and outputs sampled on the falling edge.
module tb_truth_table_sweeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] cmp_mask = 2'b00;
   logic [1:0] dut_out;
   logic [1:0] exp_out;
   logic [2:0] stim;
   logic       busy, done, pass;
   logic [3:0] mismatch_cnt;
   logic [2:0] first_fail_vec;
   logic       first_fail_valid;

   logic       mode = 1'b0;  // 0: dut=exp=stim[1:0]; 1: majority golden, faulty dut at 3 and 6
   logic       maj;

   int n_vec = 0;
   int n_bad = 0;

   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE_CYC(2)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .cmp_mask         (cmp_mask),
      .dut_out          (dut_out),
      .exp_out          (exp_out),
      .stim             (stim),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .mismatch_cnt     (mismatch_cnt),
      .first_fail_vec   (first_fail_vec),
      .first_fail_valid (first_fail_valid)
   );

   always #5 clk = ~clk;

   // Golden model and the DUT stand-in, both purely combinational on stim.
   always_comb begin
      maj = (stim[0] & stim[1]) | (stim[0] & stim[2]) | (stim[1] & stim[2]);
      if (mode) begin
         exp_out = {stim[1], maj};
         dut_out = {stim[1], maj ^ ((stim == 3'd3) || (stim == 3'd6))};
      end else begin
         exp_out = stim[1:0];
         dut_out = stim[1:0];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic chk_results(input string tag, input int mm, input int ffv, input int ffvalid, input int p);
      chk({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), mm);
      chk({tag, ".first_fail_valid"}, 32'(first_fail_valid), ffvalid);
      if (ffvalid != 0) chk({tag, ".first_fail_vec"}, 32'(first_fail_vec), ffv);
      chk({tag, ".pass"}, 32'(pass), p);
   endtask

   // Starts a sweep from IDLE at a falling edge, checks stim/busy/done each cycle.
   // ncyc: cycles expected before done; extra_start/abort_at: cycle to pulse those inputs.
   task automatic sweep(input logic [1:0] mask, input int ncyc, input int extra_start,
                        input int abort_at, input int final_stim);
      cmp_mask = mask;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      cmp_mask = ~mask;  // mask must have been latched at start
      for (int c = 1; c <= ncyc; c++) begin
         chk($sformatf("stim.c%0d", c), 32'(stim), (c - 1) / 3);
         chk($sformatf("busy.c%0d", c), 32'(busy), 1);
         chk($sformatf("done.c%0d", c), 32'(done), 0);
         start = (c == extra_start);
         abort = (c == abort_at);
         @(negedge clk);
         if (c == abort_at) begin
            abort = 1'b0;
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
      chk("done.pulse", 32'(done), 1);
      chk("done.busy", 32'(busy), 0);
      chk("done.stim", 32'(stim), final_stim);
      @(negedge clk);
      chk("after_done.done", 32'(done), 0);
      chk("after_done.busy", 32'(busy), 0);
      chk("after_done.stim", 32'(stim), final_stim);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst.stim", 32'(stim), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk_results("rst", 0, 0, 0, 0);
      chk("rst.ffv", 32'(first_fail_vec), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle.busy", 32'(busy), 0);

      // Clean sweep, with a stray start pulse mid-sweep that must be ignored
      mode = 1'b0;
      sweep(2'b11, 24, 7, 0, 7);
      chk_results("clean", 0, 0, 0, 1);

      // start and abort together in IDLE: nothing starts
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("sa.busy", 32'(busy), 0);
      @(negedge clk);
      chk("sa.busy2", 32'(busy), 0);
      chk("sa.stim", 32'(stim), 7);
      chk("sa.pass_held", 32'(pass), 1);

      // Faulty DUT, full mask
      mode = 1'b1;
`ifdef TTS_STOP_ON_FAIL_EN
      sweep(2'b11, 12, 0, 0, 3);
      chk_results("fault", 1, 3, 1, 0);
`else
      sweep(2'b11, 24, 0, 0, 7);
      chk_results("fault", 2, 3, 1, 0);
`endif

      // Faulty DUT, only bit1 compared
      sweep(2'b10, 24, 0, 0, 7);
      chk_results("masked", 0, 0, 0, 1);

      // Abort during vector 4 settle (cycle 13)
`ifdef TTS_STOP_ON_FAIL_EN
      sweep(2'b10, 24, 0, 13, 0);
      chk_results("abort", 0, 0, 0, 0);
`else
      sweep(2'b11, 24, 0, 13, 0);
      chk_results("abort", 1, 3, 1, 0);
`endif
      chk("abort.busy", 32'(busy), 0);
      chk("abort.done", 32'(done), 0);
      chk("abort.stim", 32'(stim), 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("abort.nodone%0d", i), 32'(done), 0);
      end

      // Fresh sweep after abort
      mode = 1'b0;
      sweep(2'b11, 24, 0, 0, 7);
      chk_results("fresh", 0, 0, 0, 1);

      // Reset during vector 5 with a captured failure pending
      mode = 1'b1;
      cmp_mask = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
`ifndef TTS_STOP_ON_FAIL_EN
      chk("prerst.stim", 32'(stim), 5);
      chk("prerst.mm", 32'(mismatch_cnt), 1);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.stim", 32'(stim), 0);
      chk("arst.busy", 32'(busy), 0);
      chk("arst.done", 32'(done), 0);
      chk("arst.ffv", 32'(first_fail_vec), 0);
      chk_results("arst", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst.done", 32'(done), 0);
      mode = 1'b0;
      sweep(2'b11, 24, 0, 0, 7);
      chk_results("postrst", 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
